alu_ctrl_stage: RTL and testbench

Registered, stall-aware successor to the combinational ALU control decoder for the pipelined MIPS core; sits at the ID/EX boundary. Decodes opcode/funct into ALU control and side-band signals, registers them with a valid/stall/flush protocol, and adds the HI/LO multiply/divide ops. A cycle counter tracks the multi-cycle multiply/divide unit and back-pressures dependent instructions (MULT/DIV/MFHI/MFLO) until it drains.

---
 rtl/alu_ctrl_stage.sv | 161 ++++++++++++++++
 tb/tb_alu_ctrl_stage.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_stage.sv
// ID/EX ALU control stage: decodes opcode/funct into registered ALU controls under a
// valid/stall/flush protocol and tracks mul/div occupancy to hold HI/LO-dependent ops.
module alu_ctrl_stage #(
    parameter int CTRL_W     = 6,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter bit ROTR_EN    = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [5:0]        i_aluOp,
    input  logic [5:0]        i_func,
    input  logic              i_r_field,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              o_ready,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_aluControl,
    output logic              o_ALUSrc_op1,
    output logic              o_jr,
    output logic              o_nop,
    output logic              o_md_start,
    output logic [1:0]        o_md_op,
    output logic [1:0]        o_hilo_rd,
    output logic              o_md_busy,
    output logic              o_illegal
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] ALU_ADD   = 6'b100000;
    localparam logic [5:0] ALU_SUB   = 6'b100010;
    localparam logic [5:0] ALU_AND   = 6'b100100;
    localparam logic [5:0] ALU_OR    = 6'b100101;
    localparam logic [5:0] ALU_XOR   = 6'b100110;
    localparam logic [5:0] ALU_LUI   = 6'b111100;
    localparam logic [5:0] ALU_ROTR  = 6'b111110;
    localparam logic [5:0] ALU_ROTRV = 6'b111111;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              src_op1;
        logic              jr;
        logic              nop;
        logic              md_start;
        logic [1:0]        md_op;
        logic [1:0]        hilo_rd;
        logic              illegal;
    } ctrl_t;

    ctrl_t            dec;
    ctrl_t            ctrl_p0;
    logic             vld_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic [5:0]       code;
    logic             rot;
    logic             hz;
    logic             accept;

    assign rot = ROTR_EN & i_r_field;

    always_comb begin
        dec  = '0;
        code = 6'd0;
        case (i_aluOp)
            OP_RTYPE: begin
                case (i_func)
                    6'h00: begin
                        dec.nop     = 1'b1;
                        dec.src_op1 = 1'b1;
                    end
                    6'h02: begin
                        code        = rot ? ALU_ROTR : i_func;
                        dec.src_op1 = 1'b1;
                    end
                    6'h03: begin
                        code        = i_func;
                        dec.src_op1 = 1'b1;
                    end
                    6'h06:   code = rot ? ALU_ROTRV : i_func;
                    6'h08: begin
                        code   = i_func;
                        dec.jr = 1'b1;
                    end
                    6'h04, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: code = i_func;
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        dec.md_start = 1'b1;
                        dec.md_op    = i_func[1:0];
                    end
                    6'h10:   dec.hilo_rd = 2'b10;
                    6'h12:   dec.hilo_rd = 2'b01;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: code = ALU_ADD;
            OP_BEQ, OP_BNE:                  code = ALU_SUB;
            OP_LUI:                          code = ALU_LUI;
            OP_ORI:                          code = ALU_OR;
            OP_XORI:                         code = ALU_XOR;
            OP_ANDI:                         code = ALU_AND;
            default:                         dec.illegal = 1'b1;
        endcase
        dec.ctrl[5:0] = code;
    end

    // Only ops touching HI/LO wait on the mul/div unit; everything else flows past it.
    assign hz      = (cnt_p0 != '0) & (dec.md_start | (|dec.hilo_rd));
    assign o_ready = i_rst_n & ~i_stall & ~hz;
    assign accept  = i_valid & o_ready;

    // ---- stage p0: ID/EX register ----
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            vld_p0  <= 1'b0;
            ctrl_p0 <= '0;
        end else if (i_stall) begin
            ctrl_p0.md_start <= 1'b0;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            ctrl_p0 <= dec;
        end else begin
            vld_p0  <= 1'b0;
            ctrl_p0 <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_p0 <= '0;
        end else if (accept && dec.md_start && !i_flush) begin
            cnt_p0 <= dec.md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        end else if (cnt_p0 != '0) begin
            cnt_p0 <= cnt_p0 - CNT_W'(1);
        end
    end

    assign o_valid      = vld_p0;
    assign o_aluControl = ctrl_p0.ctrl;
    assign o_ALUSrc_op1 = ctrl_p0.src_op1;
    assign o_jr         = ctrl_p0.jr;
    assign o_nop        = ctrl_p0.nop;
    assign o_md_start   = ctrl_p0.md_start;
    assign o_md_op      = ctrl_p0.md_op;
    assign o_hilo_rd    = ctrl_p0.hilo_rd;
    assign o_illegal    = ctrl_p0.illegal;
    assign o_md_busy    = (cnt_p0 != '0);

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Bench for alu_ctrl_stage: scoreboard of expected stage contents plus per-scenario
// checks of ready, busy and hold behaviour; a second instance covers ROTR_EN=0.
module tb_alu_ctrl_stage;
    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 32;

    localparam logic [5:0] OP_R = 6'h00, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12, F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A;
    localparam logic [5:0] F_DIVU = 6'h1B, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

    typedef struct packed {
        logic       vld;
        logic [5:0] ctrl;
        logic       src;
        logic       jr;
        logic       nop;
        logic       mds;
        logic [1:0] mdop;
        logic [1:0] hilo;
        logic       ill;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic [5:0] i_aluOp = 6'h0;
    logic [5:0] i_func = 6'h0;
    logic       i_r_field = 1'b0;
    logic       i_stall = 1'b0;
    logic       i_flush = 1'b0;

    logic       o_ready, o_valid, o_ALUSrc_op1, o_jr, o_nop, o_md_start, o_md_busy, o_illegal;
    logic [5:0] o_aluControl;
    logic [1:0] o_md_op, o_hilo_rd;
    logic       o0_ready, o0_valid, o0_ALUSrc_op1, o0_jr, o0_nop, o0_md_start, o0_md_busy, o0_illegal;
    logic [5:0] o0_aluControl;
    logic [1:0] o0_md_op, o0_hilo_rd;

    int   n_tests = 0;
    int   n_fail = 0;
    rec_t sb_q[$];
    logic acc_flag = 1'b0;
    rec_t last_exp = '0;

    alu_ctrl_stage #(.CTRL_W(6), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .ROTR_EN(1'b1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_aluOp(i_aluOp), .i_func(i_func),
        .i_r_field(i_r_field), .i_stall(i_stall), .i_flush(i_flush), .o_ready(o_ready),
        .o_valid(o_valid), .o_aluControl(o_aluControl), .o_ALUSrc_op1(o_ALUSrc_op1), .o_jr(o_jr),
        .o_nop(o_nop), .o_md_start(o_md_start), .o_md_op(o_md_op), .o_hilo_rd(o_hilo_rd),
        .o_md_busy(o_md_busy), .o_illegal(o_illegal)
    );

    alu_ctrl_stage #(.CTRL_W(6), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .ROTR_EN(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_aluOp(i_aluOp), .i_func(i_func),
        .i_r_field(i_r_field), .i_stall(i_stall), .i_flush(i_flush), .o_ready(o0_ready),
        .o_valid(o0_valid), .o_aluControl(o0_aluControl), .o_ALUSrc_op1(o0_ALUSrc_op1), .o_jr(o0_jr),
        .o_nop(o0_nop), .o_md_start(o0_md_start), .o_md_op(o0_md_op), .o_hilo_rd(o0_hilo_rd),
        .o_md_busy(o0_md_busy), .o_illegal(o0_illegal)
    );

    always #5 clk = ~clk;

    // Expected stage contents for an accepted instruction (ROTR_EN=1 instance).
    function automatic rec_t ref_decode(input logic [5:0] op, input logic [5:0] fn, input logic r);
        rec_t e;
        e = '0;
        e.vld = 1'b1;
        if (op == OP_R) begin
            case (fn)
                F_SLL: begin e.nop = 1'b1; e.src = 1'b1; end
                F_SRL: begin e.src = 1'b1; e.ctrl = r ? 6'b111110 : 6'b000010; end
                F_SRA: begin e.src = 1'b1; e.ctrl = 6'b000011; end
                F_SRLV: e.ctrl = r ? 6'b111111 : 6'b000110;
                F_JR: begin e.jr = 1'b1; e.ctrl = 6'b001000; end
                F_SLLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
                F_XOR, F_NOR, F_SLT, F_SLTU: e.ctrl = fn;
                F_MULT:  begin e.mds = 1'b1; e.mdop = 2'b00; end
                F_MULTU: begin e.mds = 1'b1; e.mdop = 2'b01; end
                F_DIV:   begin e.mds = 1'b1; e.mdop = 2'b10; end
                F_DIVU:  begin e.mds = 1'b1; e.mdop = 2'b11; end
                F_MFHI:  e.hilo = 2'b10;
                F_MFLO:  e.hilo = 2'b01;
                default: e.ill = 1'b1;
            endcase
        end else begin
            case (op)
                OP_ADDI, OP_ADDIU, OP_LW, OP_SW: e.ctrl = 6'b100000;
                OP_BEQ, OP_BNE: e.ctrl = 6'b100010;
                OP_LUI:  e.ctrl = 6'b111100;
                OP_ORI:  e.ctrl = 6'b100101;
                OP_XORI: e.ctrl = 6'b100110;
                OP_ANDI: e.ctrl = 6'b100100;
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    // Scoreboard: every cycle the stage contents are compared with what the protocol implies.
    always @(posedge clk) begin : scoreboard
        logic e_rst, e_fl, e_st, e_acc;
        rec_t exp_r, act_r;
        e_rst = ~rst_n;
        e_fl  = i_flush;
        e_st  = i_stall;
        e_acc = acc_flag;
        #1;
        act_r = {o_valid, o_aluControl, o_ALUSrc_op1, o_jr, o_nop, o_md_start, o_md_op, o_hilo_rd, o_illegal};
        if (e_rst || e_fl) begin
            exp_r = '0;
        end else if (e_st) begin
            exp_r = last_exp;
            exp_r.mds = 1'b0;
        end else if (e_acc) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow t=%0t: no expected entry queued", $time);
                exp_r = '0;
            end else begin
                exp_r = sb_q.pop_front();
            end
        end else begin
            exp_r = '0;
        end
        last_exp = exp_r;
        n_tests++;
        if (act_r !== exp_r) begin
            n_fail++;
            $display("FAIL stage_out t=%0t got %h want %h", $time, act_r, exp_r);
        end
    end

    task automatic set_in(input logic v, input logic [5:0] op, input logic [5:0] fn, input logic r,
                          input logic st, input logic fl, input logic acc);
        i_valid   = v;
        i_aluOp   = op;
        i_func    = fn;
        i_r_field = r;
        i_stall   = st;
        i_flush   = fl;
        acc_flag  = acc;
        if (acc) sb_q.push_back(ref_decode(op, fn, r));
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        idle();
        while (o_md_busy === 1'b1 && k < 64) begin
            tick();
            idle();
            k++;
        end
        n_tests++;
        if (o_md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout busy=%b after %0d cycles, want 0", o_md_busy, k);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, OP_ADDI, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if ({o_ready, o0_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_ready got %b%b want 00", o_ready, o0_ready);
            end
            tick();
            n_tests++;
            if ({o_valid, o_aluControl, o_ALUSrc_op1, o_jr, o_nop, o_md_start, o_md_op, o_hilo_rd,
                 o_md_busy, o_illegal, o0_valid, o0_aluControl, o0_ALUSrc_op1, o0_jr, o0_nop,
                 o0_md_start, o0_md_op, o0_hilo_rd, o0_md_busy, o0_illegal} !== 34'h0) begin
                n_fail++;
                $display("FAIL reset_outputs valid=%b ctrl=%h busy=%b want all zero", o_valid, o_aluControl, o_md_busy);
            end
        end
        rst_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_addi();
        set_in(1'b1, OP_ADDI, 6'h15, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL addi_ready got %b want 1", o_ready);
        end
        tick();
        n_tests++;
        if ({o_valid, o_aluControl} !== {1'b1, 6'b100000}) begin
            n_fail++;
            $display("FAIL addi_ctrl got v=%b %b want v=1 100000", o_valid, o_aluControl);
        end
        idle();
        tick();
    endtask

    task automatic test_rotate();
        set_in(1'b1, OP_R, F_SRL, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({o_aluControl, o_ALUSrc_op1, o0_aluControl, o0_ALUSrc_op1} !== {6'b111110, 1'b1, 6'b000010, 1'b1}) begin
            n_fail++;
            $display("FAIL rotr got %b/%b rot0 %b/%b want 111110/1 000010/1",
                     o_aluControl, o_ALUSrc_op1, o0_aluControl, o0_ALUSrc_op1);
        end
        set_in(1'b1, OP_R, F_SRLV, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({o_aluControl, o_ALUSrc_op1, o0_aluControl, o0_ALUSrc_op1} !== {6'b111111, 1'b0, 6'b000110, 1'b0}) begin
            n_fail++;
            $display("FAIL rotrv got %b/%b rot0 %b/%b want 111111/0 000110/0",
                     o_aluControl, o_ALUSrc_op1, o0_aluControl, o0_ALUSrc_op1);
        end
        set_in(1'b1, OP_R, F_SRL, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({o_aluControl, o0_aluControl} !== {6'b000010, 6'b000010}) begin
            n_fail++;
            $display("FAIL srl_plain got %b rot0 %b want 000010 000010", o_aluControl, o0_aluControl);
        end
        idle();
        tick();
    endtask

    task automatic test_decode_table();
        logic [5:0] ops [22] = '{OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_LUI, OP_ORI, OP_XORI,
                                 OP_ANDI, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R,
                                 OP_R, OP_R, OP_R, OP_R};
        logic [5:0] fns [22] = '{6'h3F, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                                 F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT, F_SLTU, F_NOR, F_XOR,
                                 F_SLLV, F_SRAV, F_SRA, F_SLL};
        for (int i = 0; i < 22; i++) begin
            set_in(1'b1, ops[i], fns[i], 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            n_tests++;
            if (o_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_valid idx=%0d got %b want 1", i, o_valid);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_mult_mflo();
        set_in(1'b1, OP_R, F_MULT, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({o_md_start, o_md_op, o_md_busy} !== 4'b1001) begin
            n_fail++;
            $display("FAIL mult_start got start=%b op=%b busy=%b want 1 00 1", o_md_start, o_md_op, o_md_busy);
        end
        for (int i = 0; i < MUL_CYCLES; i++) begin
            set_in(1'b1, OP_R, F_MFLO, 1'b0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if ({o_ready, o_md_busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL mflo_hold cyc=%0d got ready=%b busy=%b want 0 1", i, o_ready, o_md_busy);
            end
            tick();
            if (i == 0) begin
                n_tests++;
                if (o_md_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL md_start_pulse got %b want 0", o_md_start);
                end
            end
        end
        set_in(1'b1, OP_R, F_MFLO, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({o_ready, o_md_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL mflo_release got ready=%b busy=%b want 1 0", o_ready, o_md_busy);
        end
        tick();
        n_tests++;
        if (o_hilo_rd !== 2'b01) begin
            n_fail++;
            $display("FAIL mflo_hilo got %b want 01", o_hilo_rd);
        end
        idle();
        tick();
    endtask

    task automatic test_div_add();
        int busy_cycles;
        set_in(1'b1, OP_R, F_DIV, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b1, OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({o_ready, o_md_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL add_no_hazard got ready=%b busy=%b want 1 1", o_ready, o_md_busy);
        end
        tick();
        n_tests++;
        if ({o_aluControl, o_md_start} !== {6'h20, 1'b0}) begin
            n_fail++;
            $display("FAIL add_after_div got ctrl=%h start=%b want 20 0", o_aluControl, o_md_start);
        end
        busy_cycles = 1;
        for (int i = 0; i < 40 && o_md_busy === 1'b1; i++) begin
            idle();
            busy_cycles++;
            tick();
        end
        n_tests++;
        if (busy_cycles != DIV_CYCLES) begin
            n_fail++;
            $display("FAIL div_busy_len got %0d want %0d", busy_cycles, DIV_CYCLES);
        end
    endtask

    task automatic test_stall_jr();
        set_in(1'b1, OP_R, F_JR, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, OP_R, F_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (o_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ready cyc=%0d got %b want 0", i, o_ready);
            end
            tick();
            n_tests++;
            if ({o_valid, o_jr, o_aluControl} !== {1'b1, 1'b1, 6'h08}) begin
                n_fail++;
                $display("FAIL stall_hold_jr cyc=%0d got v=%b jr=%b ctrl=%h want 1 1 08", i, o_valid, o_jr, o_aluControl);
            end
        end
        set_in(1'b1, OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b1, OP_R, F_MULTU, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            n_tests++;
            if ({o_valid, o_md_start, o_md_op} !== 4'b1001) begin
                n_fail++;
                $display("FAIL stall_hold_md cyc=%0d got v=%b start=%b op=%b want 1 0 01", i, o_valid, o_md_start, o_md_op);
            end
        end
        idle();
        tick();
        drain();
    endtask

    task automatic test_flush();
        set_in(1'b1, OP_R, F_DIVU, 1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready got %b want 1", o_ready);
        end
        tick();
        n_tests++;
        if ({o_valid, o_md_start, o_md_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_divu got v=%b start=%b busy=%b want 000", o_valid, o_md_start, o_md_busy);
        end
        set_in(1'b1, OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        n_tests++;
        if ({o_valid, o_aluControl} !== 7'h00) begin
            n_fail++;
            $display("FAIL flush_kill got v=%b ctrl=%h want 0 00", o_valid, o_aluControl);
        end
        idle();
        tick();
    endtask

    task automatic test_illegal();
        set_in(1'b1, OP_R, 6'b111000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({o_valid, o_illegal, o_aluControl} !== {1'b1, 1'b1, 6'h00}) begin
            n_fail++;
            $display("FAIL illegal_funct got v=%b ill=%b ctrl=%h want 1 1 00", o_valid, o_illegal, o_aluControl);
        end
        set_in(1'b1, 6'h3F, 6'h20, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_tests++;
        if ({o_valid, o_illegal, o_aluControl} !== {1'b1, 1'b1, 6'h00}) begin
            n_fail++;
            $display("FAIL illegal_op got v=%b ill=%b ctrl=%h want 1 1 00", o_valid, o_illegal, o_aluControl);
        end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        set_in(1'b1, OP_R, F_MULT, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < MUL_CYCLES; i++) begin
            set_in(1'b1, OP_R, F_MULT, 1'b0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (o_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_mult_hold cyc=%0d got %b want 0", i, o_ready);
            end
            tick();
        end
        set_in(1'b1, OP_R, F_MULT, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_mult_ready got %b want 1", o_ready);
        end
        tick();
        n_tests++;
        if ({o_md_start, o_md_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_mult_start got start=%b busy=%b want 1 1", o_md_start, o_md_busy);
        end
        drain();
    endtask

    task automatic test_reset_mid_div();
        set_in(1'b1, OP_R, F_DIV, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            idle();
            tick();
        end
        n_tests++;
        if (o_md_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_div_busy got %b want 1", o_md_busy);
        end
        rst_n = 1'b0;
        set_in(1'b1, OP_R, F_MFHI, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ready got %b want 0", o_ready);
        end
        tick();
        n_tests++;
        if ({o_valid, o_aluControl, o_md_start, o_md_op, o_hilo_rd, o_md_busy, o_illegal} !== 14'h0) begin
            n_fail++;
            $display("FAIL rst_mid_div got v=%b ctrl=%h busy=%b want all zero", o_valid, o_aluControl, o_md_busy);
        end
        rst_n = 1'b1;
        set_in(1'b1, OP_R, F_MFHI, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({o_ready, o_md_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_residual got ready=%b busy=%b want 1 0", o_ready, o_md_busy);
        end
        tick();
        n_tests++;
        if (o_hilo_rd !== 2'b10) begin
            n_fail++;
            $display("FAIL mfhi_hilo got %b want 10", o_hilo_rd);
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rotate();
        test_decode_table();
        test_mult_mflo();
        test_div_add();
        test_stall_jr();
        test_flush();
        test_illegal();
        test_back_to_back();
        test_reset_mid_div();
        tick();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got %0d entries want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
